// File: rtl/speech_source_gen.sv
// Excitation source for the speech synthesiser: pitch pulse train, LFSR noise or a mix of both,
// with pitch-synchronous parameter latching and optional amplitude slewing.
module speech_source_gen #(
  parameter int unsigned AMP_W     = 15,
  parameter int unsigned PER_W     = 8,
  parameter int unsigned OUT_W     = 16,
  parameter int unsigned RAMP_STEP = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    strobe,
  input  logic [PER_W-1:0]        period,
  input  logic [PER_W-1:0]        pulse_len,
  input  logic [AMP_W-1:0]        amplitude,
  input  logic                    mix,
  output logic signed [OUT_W-1:0] source_out,
  output logic                    out_valid,
  output logic                    period_start
);

  localparam logic [AMP_W-1:0] Step = AMP_W'(RAMP_STEP);

  logic [PER_W-1:0] per_q, per_d;
  logic [PER_W-1:0] plen_q, plen_d;
  logic [PER_W-1:0] cnt_q, cnt_d;
  logic [AMP_W-1:0] amp_q, amp_d;
  logic [16:0]      lfsr_q, lfsr_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic             valid_q, valid_d;
  logic             pstart_q, pstart_d;

  logic             voiced;
  logic             amp_up;
  logic [AMP_W-1:0] amp_diff;
  logic [OUT_W-1:0] half_ext;
  logic [OUT_W-1:0] pulse_val;
  logic [OUT_W-1:0] noise_val;
  logic [OUT_W-1:0] noise_shr;
  logic [OUT_W:0]   mix_sum;

  // Phase counter and parameter latch: new parameters only land on a period boundary.
  always_comb begin
    per_d  = per_q;
    plen_d = plen_q;
    cnt_d  = cnt_q;
    if (strobe) begin
      if ((per_q == '0) || (cnt_q == per_q - PER_W'(1))) begin
        per_d  = period;
        plen_d = pulse_len;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + PER_W'(1);
      end
    end
  end

  // Amplitude slew toward the target without overshoot.
  always_comb begin
    amp_up   = amplitude > amp_q;
    amp_diff = amp_up ? (amplitude - amp_q) : (amp_q - amplitude);
    amp_d    = amp_q;
    if (strobe) begin
      if ((RAMP_STEP == 0) || (amp_diff <= Step)) begin
        amp_d = amplitude;
      end else if (amp_up) begin
        amp_d = amp_q + Step;
      end else begin
        amp_d = amp_q - Step;
      end
    end
  end

  always_comb begin
    lfsr_d = lfsr_q;
    if (strobe) begin
      lfsr_d = {lfsr_q[15:0], lfsr_q[16] ^ lfsr_q[2]};
    end
  end

  // Sample generation uses the post-latch phase and the freshly slewed amplitude.
  always_comb begin
    voiced    = (per_d != '0);
    half_ext  = {{(OUT_W-AMP_W){1'b0}}, (amp_d >> 1)};
    noise_val = lfsr_d[0] ? half_ext : ~half_ext;
    pulse_val = (cnt_d < plen_d) ? {{(OUT_W-AMP_W){1'b0}}, amp_d} : '0;
    noise_shr = OUT_W'($signed(noise_val) >>> 2);
    mix_sum   = {1'b0, pulse_val} + {noise_shr[OUT_W-1], noise_shr};

    out_d    = out_q;
    valid_d  = strobe;
    pstart_d = strobe && voiced && (cnt_d == '0);
    if (strobe) begin
      if (!voiced) begin
        out_d = noise_val;
      end else if (!mix) begin
        out_d = pulse_val;
      end else if (mix_sum[OUT_W] != mix_sum[OUT_W-1]) begin
        out_d = mix_sum[OUT_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
      end else begin
        out_d = mix_sum[OUT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_q    <= '0;
      plen_q   <= '0;
      cnt_q    <= '0;
      amp_q    <= '0;
      lfsr_q   <= 17'h1;
      out_q    <= '0;
      valid_q  <= 1'b0;
      pstart_q <= 1'b0;
    end else begin
      per_q    <= per_d;
      plen_q   <= plen_d;
      cnt_q    <= cnt_d;
      amp_q    <= amp_d;
      lfsr_q   <= lfsr_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
      pstart_q <= pstart_d;
    end
  end

  assign source_out   = $signed(out_q);
  assign out_valid    = valid_q;
  assign period_start = pstart_q;

endmodule

// File: tb/tb_speech_source_gen.sv
// Directed self-checking bench for speech_source_gen: voiced, boundary latch, noise, mix, ramp.
module tb_speech_source_gen;

  logic               clk;
  logic               rst;
  logic               strobe;
  logic [7:0]         period;
  logic [7:0]         pulse_len;
  logic [14:0]        amplitude;
  logic               mix;
  logic signed [15:0] source_out;
  logic               out_valid;
  logic               period_start;
  logic signed [15:0] ramp_out;
  logic               ramp_valid;
  logic               ramp_pstart;

  int n_cmp;
  int n_err;

  speech_source_gen #(
    .AMP_W    (15),
    .PER_W    (8),
    .OUT_W    (16),
    .RAMP_STEP(0)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .strobe      (strobe),
    .period      (period),
    .pulse_len   (pulse_len),
    .amplitude   (amplitude),
    .mix         (mix),
    .source_out  (source_out),
    .out_valid   (out_valid),
    .period_start(period_start)
  );

  speech_source_gen #(
    .AMP_W    (15),
    .PER_W    (8),
    .OUT_W    (16),
    .RAMP_STEP(256)
  ) u_ramp (
    .clk         (clk),
    .rst         (rst),
    .strobe      (strobe),
    .period      (period),
    .pulse_len   (pulse_len),
    .amplitude   (amplitude),
    .mix         (mix),
    .source_out  (ramp_out),
    .out_valid   (ramp_valid),
    .period_start(ramp_pstart)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input logic stb);
    strobe = stb;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    strobe = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Expected sample tables
  int voiced_exp[10]  = '{1000, 1000, 0, 0, 0, 1000, 1000, 0, 0, 0};
  int bound_exp[11]   = '{1000, 1000, 0, 0, 0, 1000, 1000, 0, 1000, 1000, 0};
  int bound_ps[11]    = '{1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0};
  int noise_exp[3]    = '{-501, -501, 500};
  int mixsat_exp[5]   = '{28671, 28671, 32767, 28671, 28671};
  int mixsat_ps[5]    = '{1, 0, 0, 0, 1};
  int ramp_up_exp[5]  = '{256, 512, 768, 1000, 1000};
  int ramp_dn_exp[4]  = '{744, 488, 232, 100};

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    period    = '0;
    pulse_len = '0;
    amplitude = '0;
    mix       = 1'b0;
    strobe    = 1'b0;
    do_reset();

    check_eq("reset_out", int'(source_out), 0);
    check_eq("reset_valid", int'(out_valid), 0);
    check_eq("reset_pstart", int'(period_start), 0);

    // Voiced pulse train
    period = 8'd5; pulse_len = 8'd2; amplitude = 15'd1000; mix = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b1);
      check_eq($sformatf("voiced_out[%0d]", i), int'(source_out), voiced_exp[i]);
      check_eq($sformatf("voiced_ps[%0d]", i), int'(period_start), (i % 5 == 0) ? 1 : 0);
      check_eq($sformatf("voiced_valid[%0d]", i), int'(out_valid), 1);
    end

    // Period change mid-period lands at the next boundary
    for (int i = 0; i < 11; i++) begin
      if (i == 2) period = 8'd3;
      tick(1'b1);
      check_eq($sformatf("bound_out[%0d]", i), int'(source_out), bound_exp[i]);
      check_eq($sformatf("bound_ps[%0d]", i), int'(period_start), bound_ps[i]);
    end

    // Gap in strobe: output holds, flags drop, phase frozen
    tick(1'b1);
    check_eq("gap_pre_out", int'(source_out), 1000);
    period = 8'd7;
    for (int i = 0; i < 2; i++) begin
      tick(1'b0);
      check_eq($sformatf("gap_hold[%0d]", i), int'(source_out), 1000);
      check_eq($sformatf("gap_valid[%0d]", i), int'(out_valid), 0);
      check_eq($sformatf("gap_ps[%0d]", i), int'(period_start), 0);
    end
    tick(1'b1);
    check_eq("gap_resume0", int'(source_out), 1000);
    tick(1'b1);
    check_eq("gap_resume1", int'(source_out), 0);

    // Asynchronous reset mid-stream
    period = 8'd5;
    tick(1'b1);
    check_eq("pre_rst_out", int'(source_out), 1000);
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst_out", int'(source_out), 0);
    check_eq("async_rst_valid", int'(out_valid), 0);
    tick(1'b1);
    check_eq("rst_strobe_ignored", int'(out_valid), 0);
    strobe = 1'b0;
    rst = 1'b0;

    // Unvoiced noise from seed
    period = 8'd0; amplitude = 15'd1000;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1);
      check_eq($sformatf("noise_out[%0d]", i), int'(source_out), noise_exp[i]);
      check_eq($sformatf("noise_ps[%0d]", i), int'(period_start), 0);
    end

    // Unvoiced -> voiced mixed with saturation
    period = 8'd4; pulse_len = 8'd4; amplitude = 15'd32767; mix = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1'b1);
      check_eq($sformatf("mixsat_out[%0d]", i), int'(source_out), mixsat_exp[i]);
      check_eq($sformatf("mixsat_ps[%0d]", i), int'(period_start), mixsat_ps[i]);
    end

    // Amplitude slew on the RAMP_STEP=256 instance
    do_reset();
    period = 8'd1; pulse_len = 8'd1; amplitude = 15'd1000; mix = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1'b1);
      check_eq($sformatf("ramp_up[%0d]", i), int'(ramp_out), ramp_up_exp[i]);
      check_eq($sformatf("ramp_up_ps[%0d]", i), int'(ramp_pstart), 1);
    end
    amplitude = 15'd100;
    for (int i = 0; i < 4; i++) begin
      tick(1'b1);
      check_eq($sformatf("ramp_dn[%0d]", i), int'(ramp_out), ramp_dn_exp[i]);
    end
    check_eq("ramp_ref_immediate", int'(source_out), 100);
    tick(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/speech_source_gen.md
# speech_source_gen

Parametrised excitation source for the speech synthesiser. On every sample strobe it produces one signed excitation sample: a pitch pulse train (voiced), LFSR noise (unvoiced), or pulse plus attenuated noise (mixed). Relative to the first-generation source it adds:
- configurable widths and pulse length;
- pitch-synchronous parameter latching;
- amplitude slewing;
- output-valid and period-start flags.

It sits between the parameter sequencer and the lattice filter.

## Interface
Parameters:
- AMP_W, 15, width of unsigned amplitude
- PER_W, 8, width of period / pulse length
- OUT_W, 16, signed output width; must be ≥ AMP_W+1
- RAMP_STEP, 0, max amplitude change per strobe; 0 = amplitude applied immediately

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- strobe  input  1  sample tick; one output sample per cycle with strobe=1, back-to-back allowed
- period  input  PER_W  pitch period in samples; 0 = unvoiced
- pulse_len  input  PER_W  pulse high length in samples (voiced)
- amplitude  input  AMP_W  unsigned target amplitude
- mix  input  1  1 = add noise to voiced output
- source_out  output  OUT_W  signed excitation sample
- out_valid  output  1  one-cycle pulse, new source_out present
- period_start  output  1  one-cycle pulse with the first sample of each voiced period

## Operation
- Internal state:
  - per_q, plen_q: latched period and pulse length;
  - cnt: PER_W phase counter;
  - amp_cur: AMP_W current amplitude;
  - lfsr: 17-bit noise register.
- All state changes only on cycles with strobe=1; otherwise everything holds, and out_valid / period_start are 0.
- Parameter latching:
  - If per_q==0 (unvoiced), or cnt==per_q-1 (last sample of period): per_q←period, plen_q←pulse_len, cnt←0.
  - Otherwise cnt←cnt+1.
  - period changes mid-period take effect only at the boundary. The unvoiced→voiced transition takes effect on the next strobe.
- The sample generated uses the values after latching, i.e. the phase of the current strobe. The first voiced sample has cnt=0.
- Amplitude slew, each strobe:
  - RAMP_STEP=0: amp_cur←amplitude.
  - Otherwise amp_cur moves toward amplitude by min(RAMP_STEP, |difference|). No overshoot, no wrap.
  - The new amp_cur is used for the sample.
- LFSR:
  - Polynomial x^17+x^3+1; lfsr←{lfsr[15:0], lfsr[16]^lfsr[2]}.
  - Advances on every strobe in all modes.
  - nb = new lfsr[0].
- Sample values:
  - pulse_val = (cnt < plen_q) ? amp_cur : 0. plen_q=0 gives silence; plen_q≥per_q gives constant amp_cur.
  - noise_val = nb ? (amp_cur>>1) : ~(amp_cur>>1), i.e. −(amp_cur>>1)−1, sign-extended to OUT_W.
  - Unvoiced: source_out = noise_val.
  - Voiced, mix=0: source_out = pulse_val.
  - Voiced, mix=1: source_out = pulse_val + (noise_val>>>2), computed in OUT_W+1 bits and saturated to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
- period_start = 1 with a voiced sample whose cnt==0.

## Timing
- Latency: sample registered on the strobe cycle's clock edge, so source_out / out_valid / period_start are visible the cycle after strobe.
- source_out holds between strobes.
- Reset (asserted at any time, immediate): source_out=0, out_valid=0, period_start=0, cnt=0, per_q=0, plen_q=0, amp_cur=0, lfsr=17'h1. The first strobe after reset starts a fresh period.
- Strobe asserted during the reset-release cycle is ignored.
- Inputs are sampled only on strobe cycles; they may change freely otherwise.
- The LFSR never reaches zero; its seed is always 1.

## Test plan
- Reset: assert rst mid-stream with period=5 → all outputs 0 immediately; after release, first strobe with period=0, amplitude=1000 → source_out = −501.
- Voiced: period=5, pulse_len=2, amplitude=1000, mix=0, continuous strobe → 1000, 1000, 0, 0, 0 repeating; period_start on each first 1000; out_valid every cycle.
- Boundary latch: as above, change period to 3 at the 3rd sample → current period finishes (0, 0), then 1000, 1000, 0 repeating.
- Noise: from reset, period=0, amplitude=1000 → first three samples −501, −501, +500 (lfsr 2, 4, 9).
- Ramp: RAMP_STEP=256, voiced period=1, pulse_len=1, amplitude 0→1000 → 256, 512, 768, 1000, 1000; then amplitude=100 → 744, 488, 232, 100.
- Mixed saturation: OUT_W=16, amplitude=32767, period=4, pulse_len=4, mix=1 → samples with nb=1 saturate to 32767; samples with nb=0 give 32767 − 4096 = 28671.
